// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Serialises A/B writes and reads onto the memory pins and routes read data
// back to the requester that issued the read. An unanswered read is ended by
// a timeout counter.
module mem_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out,
  output logic                  busy,
  output logic                  rd_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  // rr_ptr / owner encoding: 0 = requester A, 1 = requester B
  state_t                r_state,        w_state_nxt;
  logic                  r_rr_ptr,       w_rr_ptr_nxt;
  logic                  r_owner,        w_owner_nxt;
  logic [CNT_W-1:0]      r_cnt,          w_cnt_nxt;
  logic                  r_a_gnt,        w_a_gnt_nxt;
  logic                  r_b_gnt,        w_b_gnt_nxt;
  logic [DATA_WIDTH-1:0] r_a_rdata,      w_a_rdata_nxt;
  logic [DATA_WIDTH-1:0] r_b_rdata,      w_b_rdata_nxt;
  logic                  r_a_rvalid,     w_a_rvalid_nxt;
  logic                  r_b_rvalid,     w_b_rvalid_nxt;
  logic                  r_mem_write_en, w_mem_write_en_nxt;
  logic                  r_mem_read_en,  w_mem_read_en_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_address,  w_mem_address_nxt;
  logic [DATA_WIDTH-1:0] r_mem_data_in,  w_mem_data_in_nxt;
  logic                  r_busy,         w_busy_nxt;
  logic                  r_rd_timeout,   w_rd_timeout_nxt;

  logic                  w_a_win;
  logic                  w_b_win;
  logic                  w_sel_we;

  // State and registered outputs; reset discards any in-flight access
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= 1'b0;
      r_owner        <= 1'b0;
      r_cnt          <= '0;
      r_a_gnt        <= 1'b0;
      r_b_gnt        <= 1'b0;
      r_a_rdata      <= '0;
      r_b_rdata      <= '0;
      r_a_rvalid     <= 1'b0;
      r_b_rvalid     <= 1'b0;
      r_mem_write_en <= 1'b0;
      r_mem_read_en  <= 1'b0;
      r_mem_address  <= '0;
      r_mem_data_in  <= '0;
      r_busy         <= 1'b0;
      r_rd_timeout   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_owner        <= w_owner_nxt;
      r_cnt          <= w_cnt_nxt;
      r_a_gnt        <= w_a_gnt_nxt;
      r_b_gnt        <= w_b_gnt_nxt;
      r_a_rdata      <= w_a_rdata_nxt;
      r_b_rdata      <= w_b_rdata_nxt;
      r_a_rvalid     <= w_a_rvalid_nxt;
      r_b_rvalid     <= w_b_rvalid_nxt;
      r_mem_write_en <= w_mem_write_en_nxt;
      r_mem_read_en  <= w_mem_read_en_nxt;
      r_mem_address  <= w_mem_address_nxt;
      r_mem_data_in  <= w_mem_data_in_nxt;
      r_busy         <= w_busy_nxt;
      r_rd_timeout   <= w_rd_timeout_nxt;
    end
  end

  // Next-state, arbitration and next-output decode; pulses default to 0
  always_comb begin
    w_state_nxt        = r_state;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_owner_nxt        = r_owner;
    w_cnt_nxt          = r_cnt;
    w_a_gnt_nxt        = 1'b0;
    w_b_gnt_nxt        = 1'b0;
    w_a_rdata_nxt      = r_a_rdata;
    w_b_rdata_nxt      = r_b_rdata;
    w_a_rvalid_nxt     = 1'b0;
    w_b_rvalid_nxt     = 1'b0;
    w_mem_write_en_nxt = 1'b0;
    w_mem_read_en_nxt  = 1'b0;
    w_mem_address_nxt  = '0;
    w_mem_data_in_nxt  = '0;
    w_rd_timeout_nxt   = 1'b0;
    w_a_win            = 1'b0;
    w_b_win            = 1'b0;
    w_sel_we           = 1'b0;

    case (r_state)
      IDLE: begin
        // Contested: rr_ptr decides; uncontested: the lone requester wins
        w_a_win = a_req & (~b_req | ~r_rr_ptr);
        w_b_win = b_req & (~a_req |  r_rr_ptr);
        if (w_a_win || w_b_win) begin
          w_owner_nxt       = w_b_win;
          w_rr_ptr_nxt      = ~w_b_win;
          w_a_gnt_nxt       = w_a_win;
          w_b_gnt_nxt       = w_b_win;
          w_mem_address_nxt = w_b_win ? b_addr : a_addr;
          w_sel_we          = w_b_win ? b_we : a_we;
          if (w_sel_we) begin
            w_mem_write_en_nxt = 1'b1;
            w_mem_data_in_nxt  = w_b_win ? b_wdata : a_wdata;
            w_state_nxt        = WRITE;
          end else begin
            w_mem_read_en_nxt = 1'b1;
            w_cnt_nxt         = '0;
            w_state_nxt       = RD_WAIT;
          end
        end
      end

      WRITE: begin
        w_state_nxt = IDLE;
      end

      RD_WAIT: begin
        // Returned data takes precedence over a coincident timeout
        if (mem_valid_out) begin
          if (r_owner) begin
            w_b_rdata_nxt  = mem_data_out;
            w_b_rvalid_nxt = 1'b1;
          end else begin
            w_a_rdata_nxt  = mem_data_out;
            w_a_rvalid_nxt = 1'b1;
          end
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_rd_timeout_nxt = 1'b1;
          w_cnt_nxt        = '0;
          w_state_nxt      = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign a_gnt        = r_a_gnt;
  assign b_gnt        = r_b_gnt;
  assign a_rdata      = r_a_rdata;
  assign b_rdata      = r_b_rdata;
  assign a_rvalid     = r_a_rvalid;
  assign b_rvalid     = r_b_rvalid;
  assign mem_write_en = r_mem_write_en;
  assign mem_read_en  = r_mem_read_en;
  assign mem_address  = r_mem_address;
  assign mem_data_in  = r_mem_data_in;
  assign busy         = r_busy;
  assign rd_timeout   = r_rd_timeout;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with hand-computed expected values.
module tb_mem_rr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          reset_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_write_en, mem_read_en, mem_valid_out;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          busy, rd_timeout;

  int n_total;
  int n_bad;

  mem_rr_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_rdata      (a_rdata),
    .a_rvalid     (a_rvalid),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_rdata      (b_rdata),
    .b_rvalid     (b_rvalid),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_valid_out(mem_valid_out),
    .busy         (busy),
    .rd_timeout   (rd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    a_req         = 1'b0;
    a_we          = 1'b0;
    a_addr        = '0;
    a_wdata       = '0;
    b_req         = 1'b0;
    b_we          = 1'b0;
    b_addr        = '0;
    b_wdata       = '0;
    mem_data_out  = '0;
    mem_valid_out = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_a_gnt", 64'(a_gnt), 64'd0);
    check_eq("rst_b_gnt", 64'(b_gnt), 64'd0);
    check_eq("rst_wr_en", 64'(mem_write_en), 64'd0);
    check_eq("rst_rd_en", 64'(mem_read_en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_tmo", 64'(rd_timeout), 64'd0);
    check_eq("rst_addr", 64'(mem_address), 64'd0);
    check_eq("rst_a_rdata", 64'(a_rdata), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: lone A write, addr 3
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 32'hDEADBEEF;
    tick();
    check_eq("w_a_gnt", 64'(a_gnt), 64'd1);
    check_eq("w_b_gnt", 64'(b_gnt), 64'd0);
    check_eq("w_wr_en", 64'(mem_write_en), 64'd1);
    check_eq("w_rd_en", 64'(mem_read_en), 64'd0);
    check_eq("w_addr", 64'(mem_address), 64'd3);
    check_eq("w_data", 64'(mem_data_in), 64'hDEADBEEF);
    check_eq("w_busy", 64'(busy), 64'd1);
    a_req = 1'b0;
    tick();
    check_eq("w2_wr_en", 64'(mem_write_en), 64'd0);
    check_eq("w2_a_gnt", 64'(a_gnt), 64'd0);
    check_eq("w2_busy", 64'(busy), 64'd0);

    // 2: lone A read addr 3, valid_out on the second edge after the grant
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    tick();
    check_eq("r_a_gnt", 64'(a_gnt), 64'd1);
    check_eq("r_rd_en", 64'(mem_read_en), 64'd1);
    check_eq("r_wr_en", 64'(mem_write_en), 64'd0);
    check_eq("r_addr", 64'(mem_address), 64'd3);
    check_eq("r_busy", 64'(busy), 64'd1);
    a_req = 1'b0;
    tick();
    check_eq("r_rd_en_drop", 64'(mem_read_en), 64'd0);
    check_eq("r_busy_wait", 64'(busy), 64'd1);
    check_eq("r_rvalid_early", 64'(a_rvalid), 64'd0);
    mem_valid_out = 1'b1; mem_data_out = 32'hDEADBEEF;
    tick();
    check_eq("r_a_rvalid", 64'(a_rvalid), 64'd1);
    check_eq("r_a_rdata", 64'(a_rdata), 64'hDEADBEEF);
    check_eq("r_b_rvalid", 64'(b_rvalid), 64'd0);
    check_eq("r_busy_end", 64'(busy), 64'd0);
    mem_valid_out = 1'b0; mem_data_out = '0;
    tick();
    check_eq("r_rvalid_pulse", 64'(a_rvalid), 64'd0);
    check_eq("r_rdata_hold", 64'(a_rdata), 64'hDEADBEEF);

    // 4: lone B read addr 5, memory silent -> timeout after 8 RD_WAIT edges
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd5;
    tick();
    check_eq("t_b_gnt", 64'(b_gnt), 64'd1);
    check_eq("t_addr", 64'(mem_address), 64'd5);
    b_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("t_no_tmo", 64'(rd_timeout), 64'd0);
      check_eq("t_busy", 64'(busy), 64'd1);
    end
    tick();
    check_eq("t_tmo", 64'(rd_timeout), 64'd1);
    check_eq("t_b_rvalid", 64'(b_rvalid), 64'd0);
    check_eq("t_busy_end", 64'(busy), 64'd0);
    mem_valid_out = 1'b1; mem_data_out = 32'h12345678;
    tick();
    check_eq("t_tmo_pulse", 64'(rd_timeout), 64'd0);
    check_eq("t_late_b_rv", 64'(b_rvalid), 64'd0);
    check_eq("t_late_a_rv", 64'(a_rvalid), 64'd0);
    check_eq("t_late_b_rd", 64'(b_rdata), 64'd0);
    mem_valid_out = 1'b0; mem_data_out = '0;

    // 6: A read addr 7, valid_out on the timeout edge -> rvalid wins
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd7;
    tick();
    check_eq("c_a_gnt", 64'(a_gnt), 64'd1);
    a_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    mem_valid_out = 1'b1; mem_data_out = 32'hCAFEF00D;
    tick();
    check_eq("c_a_rvalid", 64'(a_rvalid), 64'd1);
    check_eq("c_a_rdata", 64'(a_rdata), 64'hCAFEF00D);
    check_eq("c_no_tmo", 64'(rd_timeout), 64'd0);
    check_eq("c_b_rdata", 64'(b_rdata), 64'd0);
    mem_valid_out = 1'b0; mem_data_out = '0;
    tick();

    // 5: A read addr 9 (rr_ptr left at B), reset while in RD_WAIT
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd9;
    tick();
    check_eq("x_a_gnt", 64'(a_gnt), 64'd1);
    a_req = 1'b0;
    tick();
    reset_n = 1'b0;
    mem_valid_out = 1'b1; mem_data_out = 32'h0000AAAA;
    tick();
    check_eq("x_a_rvalid", 64'(a_rvalid), 64'd0);
    check_eq("x_busy", 64'(busy), 64'd0);
    check_eq("x_rd_en", 64'(mem_read_en), 64'd0);
    check_eq("x_a_rdata", 64'(a_rdata), 64'd0);
    reset_n = 1'b1;
    tick();
    check_eq("x_a_rvalid2", 64'(a_rvalid), 64'd0);
    check_eq("x_busy2", 64'(busy), 64'd0);
    mem_valid_out = 1'b0; mem_data_out = '0;

    // 3: both request writes continuously -> A, B, A, B, A, B
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_wdata = 32'h11111111;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd2; b_wdata = 32'h22222222;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("rr_a_gnt", 64'(a_gnt), (k % 2 == 0) ? 64'd1 : 64'd0);
      check_eq("rr_b_gnt", 64'(b_gnt), (k % 2 == 1) ? 64'd1 : 64'd0);
      check_eq("rr_addr", 64'(mem_address), (k % 2 == 0) ? 64'd1 : 64'd2);
      check_eq("rr_data", 64'(mem_data_in), (k % 2 == 0) ? 64'h11111111 : 64'h22222222);
      tick();
      check_eq("rr_gap_a", 64'(a_gnt), 64'd0);
      check_eq("rr_gap_b", 64'(b_gnt), 64'd0);
      check_eq("rr_gap_wr", 64'(mem_write_en), 64'd0);
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    tick();
    check_eq("end_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
